mux_scan_sampler: RTL and testbench

- Sequencer that sits directly upstream of the 16:1 mux and also consumes its output.
- Drives the mux select through channels 0..15, waits a settle time on each, then samples the mux output bit.
- After all 16 channels it presents a 16-bit snapshot word on a valid/ready output for downstream logic.
- Supports one-shot scans and continuous scans.

---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_scan_sampler_if.sv | 30 +++
 rtl/mux_scan_sampler_settle_timer.sv | 30 +++
 rtl/mux_scan_sampler.sv | 124 ++++++++++++
 tb/tb_mux_scan_sampler.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sampler block.
package mux_scan_pkg;

  localparam int NUM_CH   = 16;
  localparam int SEL_W    = 4;
  localparam int SETTLE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    HOLD
  } state_t;

  typedef logic [SEL_W-1:0]  ch_t;
  typedef logic [NUM_CH-1:0] snap_t;

endpackage

// File: rtl/mux_scan_sampler_if.sv
// Snapshot valid/ready stream. Optional MUX_SCAN_PARITY_EN adds snap_parity.
interface mux_scan_sampler_if;
  import mux_scan_pkg::*;

  snap_t snap_data;
  logic  snap_valid;
  logic  snap_ready;
`ifdef MUX_SCAN_PARITY_EN
  logic  snap_parity;
`endif

  modport master (
`ifdef MUX_SCAN_PARITY_EN
    output snap_parity,
`endif
    output snap_data,
    output snap_valid,
    input  snap_ready
  );

  modport slave (
`ifdef MUX_SCAN_PARITY_EN
    input  snap_parity,
`endif
    input  snap_data,
    input  snap_valid,
    output snap_ready
  );

endinterface

// File: rtl/mux_scan_sampler_settle_timer.sv
// Settle counter: counts cycles while enabled, clear wins; tc flags the last settle cycle.
module scan_settle_timer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [SETTLE_W-1:0] TC_VAL = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + SETTLE_W'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mux_scan_sampler.sv
// Scans a 16:1 mux channel by channel and publishes a 16-bit snapshot on a valid/ready stream.
// Optional MUX_SCAN_PARITY_EN: registered snap_parity = ^snap_data. SETTLE_CYCLES legal range 1..255.
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cont,
  input  logic               abort,
  input  logic               mux_y,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  mux_scan_sampler_if.master snap
);

  state_t              state_q, state_nxt;
  ch_t                 ch_q, ch_nxt;
  logic [NUM_CH-2:0]   shadow_q, shadow_nxt;
  snap_t               data_q, data_nxt;
  logic                vld_q, vld_nxt;
  logic                tmr_clr, tmr_en, tmr_tc;

  // Timer runs only in SETTLE, so every entry into SETTLE starts from zero.
  assign tmr_en  = (state_q == SETTLE);
  assign tmr_clr = !tmr_en || abort;

  scan_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .tc   (tmr_tc)
  );

  always_comb begin
    state_nxt  = state_q;
    ch_nxt     = ch_q;
    shadow_nxt = shadow_q;
    data_nxt   = data_q;
    vld_nxt    = vld_q;
    if (abort) begin
      state_nxt  = IDLE;
      ch_nxt     = '0;
      shadow_nxt = '0;
      vld_nxt    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_nxt = SETTLE;
            ch_nxt    = '0;
          end
        end
        SETTLE: begin
          if (tmr_tc) state_nxt = SAMPLE;
        end
        SAMPLE: begin
          if (ch_q == ch_t'(NUM_CH - 1)) begin
            data_nxt  = {mux_y, shadow_q};
            vld_nxt   = 1'b1;
            state_nxt = HOLD;
          end else begin
            shadow_nxt[ch_q] = mux_y;
            ch_nxt           = ch_q + ch_t'(1);
            state_nxt        = SETTLE;
          end
        end
        HOLD: begin
          // Scan stalls here until the snapshot is taken; ch wraps only on this edge.
          if (snap.snap_ready) begin
            vld_nxt   = 1'b0;
            ch_nxt    = '0;
            state_nxt = cont ? SETTLE : IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          ch_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      ch_q     <= ch_nxt;
      shadow_q <= shadow_nxt;
      data_q   <= data_nxt;
      vld_q    <= vld_nxt;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^data_nxt;
    end
  end

  assign snap.snap_parity = par_q;
`endif

  assign sel             = ch_q;
  assign busy            = (state_q != IDLE);
  assign snap.snap_data  = data_q;
  assign snap.snap_valid = vld_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler with a behavioural 16:1 mux model (mux_y = a[sel]).
module tb_mux_scan_sampler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cont;
  logic        abort;
  logic        mux_y;
  logic [3:0]  sel;
  logic        busy;
  logic [15:0] mux_a;

  int n_checks;
  int n_fail;

  mux_scan_sampler_if snap_if ();

  mux_scan_sampler #(
    .SETTLE_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .cont (cont),
    .abort(abort),
    .mux_y(mux_y),
    .sel  (sel),
    .busy (busy),
    .snap (snap_if)
  );

  assign mux_y = mux_a[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] exp_data;
    int          exp_lat;
    logic        exp_par;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // The posedge inside this task is edge 0 of the scan.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!snap_if.snap_valid && n < 200);
  endtask

  task automatic wait_sel(input logic [3:0] s);
    int n;
    n = 0;
    while (sel != s && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_sel", {28'h0, sel}, {28'h0, s});
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    cont     = 1'b0;
    abort    = 1'b0;
    mux_a    = 16'h0;
    snap_if.snap_ready = 1'b1;

    vecs[0] = '{a: 16'hA5C3, exp_data: 16'hA5C3, exp_lat: 48, exp_par: 1'b0};
    vecs[1] = '{a: 16'h0001, exp_data: 16'h0001, exp_lat: 48, exp_par: 1'b1};
    vecs[2] = '{a: 16'hFFFF, exp_data: 16'hFFFF, exp_lat: 48, exp_par: 1'b0};
    vecs[3] = '{a: 16'h8000, exp_data: 16'h8000, exp_lat: 48, exp_par: 1'b1};
    vecs[4] = '{a: 16'h1234, exp_data: 16'h1234, exp_lat: 48, exp_par: 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", {28'h0, sel}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_valid", {31'h0, snap_if.snap_valid}, 32'h0);
    chk("rst_data", {16'h0, snap_if.snap_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-shot scans with ready held high.
    for (int i = 0; i < 5; i++) begin
      mux_a = vecs[i].a;
      do_start();
      wait_valid(n);
      chk("latency", n, vecs[i].exp_lat);
      chk("snap_data", {16'h0, snap_if.snap_data}, {16'h0, vecs[i].exp_data});
`ifdef MUX_SCAN_PARITY_EN
      chk("snap_parity", {31'h0, snap_if.snap_parity}, {31'h0, vecs[i].exp_par});
`endif
      @(posedge clk);
      #1;
      chk("busy_after", {31'h0, busy}, 32'h0);
      chk("valid_after", {31'h0, snap_if.snap_valid}, 32'h0);
    end

    // Backpressure: snapshot must hold with sel parked at 15; start/cont ignored in HOLD.
    mux_a = 16'h3C5A;
    snap_if.snap_ready = 1'b0;
    do_start();
    wait_valid(n);
    chk("bp_latency", n, 48);
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {31'h0, snap_if.snap_valid}, 32'h1);
      chk("bp_data", {16'h0, snap_if.snap_data}, 32'h3C5A);
      chk("bp_sel", {28'h0, sel}, 32'hF);
    end
    start = 1'b0;
    snap_if.snap_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_accept_valid", {31'h0, snap_if.snap_valid}, 32'h0);
    chk("bp_accept_busy", {31'h0, busy}, 32'h0);

    // Continuous mode: second snapshot 48 edges after the first handshake edge.
    mux_a = 16'h00FF;
    cont  = 1'b1;
    do_start();
    wait_valid(n);
    chk("cont1_latency", n, 48);
    chk("cont1_data", {16'h0, snap_if.snap_data}, 32'h00FF);
    mux_a = 16'hFF00;
    wait_valid(n);
    chk("cont2_latency", n, 49);
    chk("cont2_data", {16'h0, snap_if.snap_data}, 32'hFF00);
    cont = 1'b0;
    @(posedge clk);
    #1;
    chk("cont_stop_busy", {31'h0, busy}, 32'h0);

    // Abort at channel 7; snap_data keeps its last value.
    mux_a = 16'h5A3C;
    do_start();
    wait_sel(4'd7);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_sel", {28'h0, sel}, 32'h0);
    chk("abort_valid", {31'h0, snap_if.snap_valid}, 32'h0);
    chk("abort_data_kept", {16'h0, snap_if.snap_data}, 32'hFF00);
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_over_start", {31'h0, busy}, 32'h0);
    do_start();
    wait_valid(n);
    chk("post_abort_latency", n, 48);
    chk("post_abort_data", {16'h0, snap_if.snap_data}, 32'h5A3C);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-SETTLE clears outputs before the next clock edge.
    mux_a = 16'h1111;
    do_start();
    wait_sel(4'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_sel", {28'h0, sel}, 32'h0);
    chk("areset_busy", {31'h0, busy}, 32'h0);
    chk("areset_valid", {31'h0, snap_if.snap_valid}, 32'h0);
    chk("areset_data", {16'h0, snap_if.snap_data}, 32'h0);
`ifdef MUX_SCAN_PARITY_EN
    chk("areset_parity", {31'h0, snap_if.snap_parity}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
